// File: rtl/pipe_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
// Holds the forwarding-select codes, the memory FSM state enum and the register-match helpers.
package pipe_pkg;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ERR  = 2'd2
   } mem_state_e;

   // Register 0 is hard-wired to zero, so it can never create a dependency.
   function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
      return (a != 5'd0) && (a == b);
   endfunction

   function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                          input logic       reg_write_m,
                                          input logic [4:0] write_reg_m,
                                          input logic       reg_write_w,
                                          input logic [4:0] write_reg_w);
      if (reg_write_m && reg_match(src, write_reg_m)) return FWD_MEM;
      if (reg_write_w && reg_match(src, write_reg_w)) return FWD_WB;
      return FWD_RF;
   endfunction

endpackage

// File: rtl/mem_wait_fsm.sv
// Data-memory access sequencer: drives dmem_req, freezes the pipeline while an access is
// outstanding, and latches a sticky error when the ack does not come within TIMEOUT WAIT cycles.
module mem_wait_fsm
   import pipe_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic memop_i,
   input  logic dmem_ack_i,
   output logic dmem_req_o,
   output logic memstall_o,
   output logic mem_err_o
);

   localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 1);

   mem_state_e state_q, state_d;
   logic [7:0] tcnt_q, tcnt_d;
   logic       err_q, err_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         tcnt_q  <= 8'd0;
         err_q   <= 1'b0;
      end else begin
         // NOTE: state updates use non-blocking assignment so every register samples pre-edge values.
         state_q <= state_d;
         tcnt_q  <= tcnt_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      tcnt_d  = tcnt_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (memop_i && !dmem_ack_i) begin
               state_d = WAIT;
               tcnt_d  = 8'd0;
            end
         end
         WAIT: begin
            if (dmem_ack_i) begin
               state_d = IDLE;
            end else if (tcnt_q == TIMEOUT_M1) begin
               state_d = ERR;
               err_d   = 1'b1;
            end else begin
               tcnt_d = tcnt_q + 8'd1;
            end
         end
         ERR:     state_d = ERR;
         default: state_d = IDLE;
      endcase
   end

   // A missed ack in IDLE already holds the pipeline, so the instruction stays in MEM.
   always_comb begin
      dmem_req_o = 1'b0;
      memstall_o = 1'b0;
      case (state_q)
         IDLE: begin
            dmem_req_o = memop_i;
            memstall_o = memop_i & ~dmem_ack_i;
         end
         WAIT: begin
            dmem_req_o = 1'b1;
            memstall_o = ~dmem_ack_i;
         end
         default: begin
            dmem_req_o = 1'b0;
            memstall_o = 1'b0;
         end
      endcase
      if (rst) begin
         dmem_req_o = 1'b0;
         memstall_o = 1'b0;
      end
   end

   assign mem_err_o = err_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage MIPS pipeline: forwarding selects,
// load-use/branch stalls, flushes, memory-wait freeze and a saturating stall-cycle counter.
module pipeline_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       RsD,
   input  logic [4:0]       RtD,
   input  logic             BranchD,
   input  logic             PCSrcD,
   input  logic [4:0]       RsE,
   input  logic [4:0]       RtE,
   input  logic [4:0]       WriteRegE,
   input  logic             RegWriteE,
   input  logic             MemtoRegE,
   input  logic [4:0]       WriteRegM,
   input  logic             RegWriteM,
   input  logic             MemtoRegM,
   input  logic             MemWriteM,
   input  logic [4:0]       WriteRegW,
   input  logic             RegWriteW,
   input  logic             dmem_ack,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             ForwardAD,
   output logic             ForwardBD,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             StallM,
   output logic             FlushD,
   output logic             FlushE,
   output logic             dmem_req,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cnt
);

   logic             memop;
   logic             memstall;
   logic             lwstall;
   logic             branchstall;
   logic             hz;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   assign memop = MemtoRegM | MemWriteM;

   mem_wait_fsm #(
      .TIMEOUT(TIMEOUT)
   ) u_mem_wait_fsm (
      .clk       (clk),
      .rst       (rst),
      .memop_i   (memop),
      .dmem_ack_i(dmem_ack),
      .dmem_req_o(dmem_req),
      .memstall_o(memstall),
      .mem_err_o (mem_err)
   );

   assign lwstall     = MemtoRegE & (reg_match(RtE, RsD) | reg_match(RtE, RtD));
   assign branchstall = BranchD &
                        ((RegWriteE & (reg_match(WriteRegE, RsD) | reg_match(WriteRegE, RtD))) |
                         (MemtoRegM & (reg_match(WriteRegM, RsD) | reg_match(WriteRegM, RtD))));
   assign hz          = lwstall | branchstall;

   always_comb begin
      // NOTE: every output gets a default before any branch, so no path can infer a latch.
      ForwardAE = FWD_RF;
      ForwardBE = FWD_RF;
      ForwardAD = 1'b0;
      ForwardBD = 1'b0;
      StallF    = 1'b0;
      StallD    = 1'b0;
      StallE    = 1'b0;
      StallM    = 1'b0;
      FlushD    = 1'b0;
      FlushE    = 1'b0;
      if (!rst) begin
         ForwardAE = fwd_sel(RsE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
         ForwardBE = fwd_sel(RtE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
         ForwardAD = RegWriteM & reg_match(RsD, WriteRegM);
         ForwardBD = RegWriteM & reg_match(RtD, WriteRegM);
         // A frozen pipeline must not be bubbled; hazards are re-evaluated after release.
         if (memstall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
         end else begin
            StallF = hz;
            StallD = hz;
            FlushE = hz;
            FlushD = PCSrcD & ~hz;
         end
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (StallF && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) stall_cnt_q <= '0;
      else     stall_cnt_q <= stall_cnt_d;
   end

   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: a behavioural model pushes expected outputs per
// cycle, a monitor pops and compares; directed test-plan checks plus randomized traffic.
module tb_pipeline_hazard_ctrl;

   localparam int TO = 4;
   localparam int CW = 5;

   typedef struct packed {
      logic [4:0] rsd, rtd;
      logic       branchd, pcsrcd;
      logic [4:0] rse, rte, wre;
      logic       rwe, m2re;
      logic [4:0] wrm;
      logic       rwm, m2rm, mwm;
      logic [4:0] wrw;
      logic       rww, ack, rst;
   } stim_t;

   typedef struct packed {
      logic [1:0]    fae, fbe;
      logic          fad, fbd, sf, sd, se, sm, fd, fe, req, err;
      logic [CW-1:0] cnt;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [4:0]    RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
   logic          BranchD, PCSrcD, RegWriteE, MemtoRegE, RegWriteM, MemtoRegM, MemWriteM;
   logic          RegWriteW, dmem_ack;
   logic [1:0]    ForwardAE, ForwardBE;
   logic          ForwardAD, ForwardBD, StallF, StallD, StallE, StallM, FlushD, FlushE;
   logic          dmem_req, mem_err;
   logic [CW-1:0] stall_cnt;

   int   n_cmp  = 0;
   int   n_fail = 0;
   int   cyc    = 0;
   exp_t exp_q[$];

   // Reference state: is an access outstanding, how long has it waited, has it timed out.
   bit m_busy, m_err;
   int m_waited, m_cnt;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .RsD(RsD), .RtD(RtD), .BranchD(BranchD), .PCSrcD(PCSrcD),
      .RsE(RsE), .RtE(RtE), .WriteRegE(WriteRegE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE),
      .WriteRegM(WriteRegM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
      .WriteRegW(WriteRegW), .RegWriteW(RegWriteW), .dmem_ack(dmem_ack),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
      .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
      .FlushD(FlushD), .FlushE(FlushE), .dmem_req(dmem_req), .mem_err(mem_err),
      .stall_cnt(stall_cnt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic bit dep(input logic [4:0] a, input logic [4:0] b);
      return (a != 0) && (a == b);
   endfunction

   function automatic logic [1:0] ex_fwd(input stim_t s, input logic [4:0] src);
      if (s.rwm && dep(src, s.wrm)) return 2'b10;
      if (s.rww && dep(src, s.wrw)) return 2'b01;
      return 2'b00;
   endfunction

   // Drive one cycle of inputs at the falling edge and queue what the DUT must show.
   task automatic apply(input stim_t s);
      exp_t e;
      bit   memop, ms, hz;
      @(negedge clk);
      cyc++;
      RsD = s.rsd; RtD = s.rtd; BranchD = s.branchd; PCSrcD = s.pcsrcd;
      RsE = s.rse; RtE = s.rte; WriteRegE = s.wre; RegWriteE = s.rwe; MemtoRegE = s.m2re;
      WriteRegM = s.wrm; RegWriteM = s.rwm; MemtoRegM = s.m2rm; MemWriteM = s.mwm;
      WriteRegW = s.wrw; RegWriteW = s.rww; dmem_ack = s.ack; rst = s.rst;
      e = '0;
      if (s.rst) begin
         m_busy = 0; m_err = 0; m_waited = 0; m_cnt = 0;
      end else begin
         e.err = m_err;
         e.cnt = CW'(m_cnt);
         e.fae = ex_fwd(s, s.rse);
         e.fbe = ex_fwd(s, s.rte);
         e.fad = s.rwm && dep(s.rsd, s.wrm);
         e.fbd = s.rwm && dep(s.rtd, s.wrm);
         hz = (s.m2re && (dep(s.rte, s.rsd) || dep(s.rte, s.rtd))) ||
              (s.branchd && ((s.rwe && (dep(s.wre, s.rsd) || dep(s.wre, s.rtd))) ||
                             (s.m2rm && (dep(s.wrm, s.rsd) || dep(s.wrm, s.rtd)))));
         memop = s.m2rm || s.mwm;
         ms = 0;
         if (m_err) begin
            e.req = 0;
         end else if (!m_busy) begin
            e.req = memop;
            ms = memop && !s.ack;
            if (ms) begin m_busy = 1; m_waited = 0; end
         end else begin
            e.req = 1;
            ms = !s.ack;
            if (s.ack) m_busy = 0;
            else begin
               m_waited++;
               if (m_waited == TO) begin m_err = 1; m_busy = 0; end
            end
         end
         if (ms) begin
            {e.sf, e.sd, e.se, e.sm} = 4'hf;
         end else begin
            e.sf = hz; e.sd = hz; e.fe = hz;
            e.fd = s.pcsrcd && !hz;
         end
         if (e.sf && m_cnt < (1 << CW) - 1) m_cnt++;
      end
      exp_q.push_back(e);
   endtask

   // Monitor: outputs are valid every cycle, sampled mid-low-phase.
   initial begin
      exp_t e, a;
      forever begin
         @(negedge clk);
         #3;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{fae: ForwardAE, fbe: ForwardBE, fad: ForwardAD, fbd: ForwardBD,
                  sf: StallF, sd: StallD, se: StallE, sm: StallM, fd: FlushD, fe: FlushE,
                  req: dmem_req, err: mem_err, cnt: stall_cnt};
            n_cmp++;
            if (a !== e) begin
               n_fail++;
               $display("FAIL scoreboard cycle %0d: got %h, want %h", cyc, a, e);
            end
         end
      end
   end

   initial begin
      stim_t s, z, r;
      int    base;
      z = '0;
      r = '0; r.rst = 1;

      // Reset state with busy-looking inputs.
      s = z; s.rst = 1; s.mwm = 1; s.rwm = 1; s.wrm = 5; s.rse = 5; s.branchd = 1; s.pcsrcd = 1;
      apply(s); #2;
      check("rst_req", dmem_req, 0);
      check("rst_fae", ForwardAE, 0);
      check("rst_stall_flush", {StallF, StallD, StallE, StallM, FlushD, FlushE}, 0);
      check("rst_cnt", stall_cnt, 0);

      // EX forwarding priority and register 0.
      s = z; s.rse = 5; s.rwm = 1; s.wrm = 5;
      apply(s); #2; check("fae_mem", ForwardAE, 2'b10);
      s.rww = 1; s.wrw = 5;
      apply(s); #2; check("fae_mem_prio", ForwardAE, 2'b10);
      s = z; s.rwm = 1; s.rww = 1; s.rte = 6; s.wrw = 6;
      apply(s); #2;
      check("fae_r0", ForwardAE, 2'b00);
      check("fbe_wb", ForwardBE, 2'b01);

      // Load-use stall for one cycle.
      base = int'(stall_cnt);
      s = z; s.m2re = 1; s.rte = 8; s.rsd = 8;
      apply(s); #2; check("lw_stall", {StallF, StallD, FlushE}, 3'b111);
      apply(z); #2;
      check("lw_cnt", stall_cnt, CW'(base + 1));
      check("lw_release", StallF, 0);

      // Branch hazard then forward from MEM; taken branch without hazard flushes D.
      s = z; s.branchd = 1; s.rwe = 1; s.wre = 3; s.rtd = 3;
      apply(s); #2; check("br_stall", {StallF, FlushE, FlushD}, 3'b110);
      s = z; s.branchd = 1; s.rtd = 3; s.rwm = 1; s.wrm = 3; s.pcsrcd = 1;
      apply(s); #2;
      check("br_fwd", ForwardBD, 1);
      check("br_nostall_flushd", {StallF, FlushD}, 2'b01);

      // Memory wait: three unacked cycles, ack on the fourth.
      apply(r);
      s = z; s.mwm = 1;
      for (int i = 0; i < 3; i++) begin
         apply(s); #2; check("mw_stall", {StallF, StallD, StallE, StallM, dmem_req}, 5'h1f);
      end
      s.ack = 1;
      apply(s); #2; check("mw_ack", {StallF, StallM, dmem_req}, 3'b001);
      apply(z); #2; check("mw_cnt", stall_cnt, 3);

      // Timeout: IDLE miss plus TO WAIT cycles, then sticky error.
      apply(r);
      s = z; s.mwm = 1;
      for (int i = 0; i < TO + 1; i++) begin
         apply(s); #2; check("to_waiting", {mem_err, StallF}, 2'b01);
      end
      apply(s); #2; check("to_err", {mem_err, StallF, StallM, dmem_req}, 4'b1000);
      apply(z); #2; check("to_sticky", mem_err, 1);
      apply(r); #2; check("to_rst_clear", mem_err, 0);

      // Reset in the middle of WAIT.
      apply(z);
      s = z; s.m2rm = 1; s.wrm = 9;
      apply(s); apply(s);
      s.rst = 1;
      apply(s); #2; check("rw_drop", {dmem_req, StallF, StallD, StallE, StallM}, 0);
      apply(z); #2;
      check("rw_cnt", stall_cnt, 0);
      check("rw_idle", {dmem_req, StallF}, 0);
      s = z; s.mwm = 1; s.ack = 1;
      apply(s); #2; check("zero_wait", {dmem_req, StallF}, 2'b10);

      // Randomized traffic with occasional reset pulses.
      for (int i = 0; i < 3000; i++) begin
         s.rsd = 5'($urandom_range(0, 7)); s.rtd = 5'($urandom_range(0, 7));
         s.rse = 5'($urandom_range(0, 7)); s.rte = 5'($urandom_range(0, 7));
         s.wre = 5'($urandom_range(0, 7)); s.wrm = 5'($urandom_range(0, 7));
         s.wrw = 5'($urandom_range(0, 7));
         s.branchd = 1'($urandom); s.pcsrcd = 1'($urandom);
         s.rwe = 1'($urandom); s.m2re = ($urandom_range(0, 3) == 0);
         s.rwm = 1'($urandom); s.rww = 1'($urandom);
         s.m2rm = ($urandom_range(0, 3) == 0); s.mwm = ($urandom_range(0, 3) == 0);
         s.ack = ($urandom_range(0, 9) < 6);
         s.rst = ($urandom_range(0, 149) == 0);
         apply(s);
      end

      apply(z);
      repeat (3) @(negedge clk);
      #5;
      if (exp_q.size() != 0) begin
         n_cmp++; n_fail++;
         $display("FAIL drain: got %0d pending, want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and sequencing controller for the 5-stage MIPS pipeline. It is the single place where forwarding, stall and flush controls are decided.
- Drives the EX/MEM forwarding selects and the per-stage stall and flush controls.
- Sequences data-memory accesses in MEM over a req/ack handshake, freezing the pipeline while memory is busy.
- Keeps a stall-cycle performance counter and a sticky memory-timeout error.

## Interface
Parameters:
- TIMEOUT, 255: maximum WAIT cycles before declaring a memory error (1..255).
- CNT_W, 32: width of the stall performance counter.

Ports:
- clk  in  1  pipeline clock. One clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- RsD, RtD  in  5 each  decode-stage source registers.
- BranchD  in  1  branch in decode.
- PCSrcD  in  1  branch taken in decode.
- RsE, RtE  in  5 each  EX-stage source registers.
- WriteRegE  in  5  EX-stage destination register.
- RegWriteE, MemtoRegE  in  1 each  EX-stage controls.
- WriteRegM  in  5  MEM-stage destination register.
- RegWriteM, MemtoRegM, MemWriteM  in  1 each  MEM-stage controls.
- WriteRegW  in  5  WB-stage destination register.
- RegWriteW  in  1  WB-stage register write.
- dmem_ack  in  1  data memory has completed the current access.
- ForwardAE, ForwardBE  out  2 each  EX operand select: 00 = register file, 01 = ResultW, 10 = ALUOutM. Code 11 is never driven.
- ForwardAD, ForwardBD  out  1 each  branch comparator takes ALUOutM.
- StallF, StallD, StallE, StallM  out  1 each  hold the pipeline register feeding the named stage.
- FlushD, FlushE  out  1 each  bubble the pipeline register feeding the named stage.
- dmem_req  out  1  memory access request.
- mem_err  out  1  sticky memory-timeout flag.
- stall_cnt  out  CNT_W  number of cycles with StallF=1.

## Operation
Forwarding (combinational):
- ForwardAE = 10 if RsE!=0 & RegWriteM & WriteRegM==RsE.
- Otherwise ForwardAE = 01 if RsE!=0 & RegWriteW & WriteRegW==RsE.
- Otherwise ForwardAE = 00.
- ForwardBE uses the same rules with RtE.
- ForwardAD = RsD!=0 & RegWriteM & WriteRegM==RsD. ForwardBD is the same with RtD.

Hazard stalls:
- lwstall = MemtoRegE & (RtE==RsD | RtE==RtD).
- branchstall = BranchD & either:
  - RegWriteE & (WriteRegE==RsD | WriteRegE==RtD), or
  - MemtoRegM & (WriteRegM==RsD | WriteRegM==RtD).
- hz = lwstall | branchstall.

Memory FSM (states IDLE, WAIT, ERR):
- memop = MemtoRegM | MemWriteM.
- IDLE: dmem_req = memop.
  - memop & dmem_ack: access completes this cycle, no stall, stay IDLE.
  - memop & !dmem_ack: go to WAIT and clear the timeout counter.
- WAIT: dmem_req=1 and memstall=1.
  - dmem_ack: memstall=0 this cycle, return to IDLE.
  - Otherwise the counter increments; when it reaches TIMEOUT, go to ERR and set mem_err.
- ERR: dmem_req=0, memstall=0, pipeline runs. mem_err stays 1 until rst.

Output combination:
- memstall=1: StallF, StallD, StallE and StallM all 1; FlushD=FlushE=0, so the frozen pipeline is not bubbled.
- Otherwise:
  - StallF = StallD = hz.
  - StallE = StallM = 0.
  - FlushE = hz.
  - FlushD = PCSrcD & !hz.
- stall_cnt increments every cycle StallF=1 and saturates at all-ones.

## Timing
- Forward, stall and flush outputs are combinational from the same-cycle inputs and the current state; they take effect at the next clk edge.
- The zero-wait case (dmem_ack in the same cycle as dmem_req) costs no stall cycle.
- An ack arriving on WAIT cycle N releases the stall in cycle N; the pipeline advances at the end of that cycle.
- While rst=1:
  - state = IDLE, timeout counter = 0, mem_err = 0, stall_cnt = 0.
  - All stall/flush outputs, ForwardAD/BD and dmem_req are forced to 0, and ForwardAE/BE are forced to 00.
- rst asserted during WAIT aborts the access immediately and dmem_req drops asynchronously.
- Simultaneous memstall and hz: memstall wins and FlushE is suppressed. hz is re-evaluated after release.
- Register 0 never forwards and never stalls.

## Structure
- Shared package pipe_pkg holds:
  - FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - The FSM state enum {IDLE, WAIT, ERR}.
- One sub-module, mem_wait_fsm, contains the FSM, the timeout counter and mem_err. It outputs dmem_req and memstall.
- Forwarding, hazard logic and stall_cnt stay in the top module.

## Test plan
- EX forwarding:
  - RsE=5, RegWriteM=1, WriteRegM=5 -> ForwardAE=10.
  - Add RegWriteW=1, WriteRegW=5 at the same time -> still 10 (MEM has priority).
  - RsE=0 with every match asserted -> 00.
- Load-use: MemtoRegE=1, RtE=8, RsD=8 -> StallF=StallD=FlushE=1 for one cycle; stall_cnt increments by 1.
- Branch hazards:
  - BranchD=1, RegWriteE=1, WriteRegE=RtD=3 -> branchstall asserted.
  - Next cycle with the instruction in MEM and RegWriteM=1, WriteRegM=3 -> ForwardBD=1 and no stall.
- Memory wait:
  - MemWriteM=1 with dmem_ack low for 3 cycles -> all four stalls high for 3 cycles.
  - Ack on the 4th cycle -> stall=0 that cycle; stall_cnt += 3.
- Timeout: TIMEOUT=4, dmem_ack held 0 -> mem_err rises after 4 WAIT cycles and stalls drop; mem_err stays 1 until rst pulse clears it.
- Reset mid-WAIT: assert rst while waiting -> dmem_req and all stalls drop at once; after release, state is IDLE and stall_cnt=0.
